sram_ctrl: RTL and testbench

//  Sequential controller between the load/store stage and one external 32-bit asynchronous SRAM.
//  - Takes word requests (ce/we/addr/byte-select/data) from the load/store stage.
//  - Drives multi-cycle, glitch-free SRAM strobes.
//  - Returns read data with a one-cycle done pulse; holds the pipeline stalled meanwhile.

---
 rtl/sram_ctrl_pkg.sv | 14 +
 rtl/sram_ctrl_rdbuf.sv | 39 +++
 rtl/sram_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the SRAM controller: FSM encodings, default widths, word constants.
package sram_ctrl_pkg;
    localparam int SRAM_ADDR_W_DEF = 20;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic        TRUE      = 1'b1;
    localparam logic        FALSE     = 1'b0;
endpackage

// File: rtl/sram_ctrl_rdbuf.sv
// One-entry last-read buffer: refilled by every completed bus read, cleared by a write
// to the buffered word. Only instantiated when SRAM_CTRL_RDBUF_EN is defined.
module sram_ctrl_rdbuf
    import sram_ctrl_pkg::*;
#(
    parameter int AW = SRAM_ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_lookup_addr,
    input  logic          i_fill,
    input  logic [AW-1:0] i_fill_addr,
    input  logic [31:0]   i_fill_data,
    input  logic          i_inv,
    input  logic [AW-1:0] i_inv_addr,
    output logic          o_hit,
    output logic [31:0]   o_data
);
    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= FALSE;
            r_addr  <= '0;
            r_data  <= ZERO_WORD;
        end else if (i_fill) begin
            r_valid <= TRUE;
            r_addr  <= i_fill_addr;
            r_data  <= i_fill_data;
        end else if (i_inv && (i_inv_addr == r_addr)) begin
            r_valid <= FALSE;
        end
    end

    assign o_hit  = r_valid && (i_lookup_addr == r_addr);
    assign o_data = r_data;
endmodule

// File: rtl/sram_ctrl.sv
// Sequential controller for one 32-bit asynchronous SRAM with registered, glitch-free strobes.
// Optional read buffer enabled by defining SRAM_CTRL_RDBUF_EN.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce_i,
    input  logic                   we_i,
    input  logic [31:0]            addr_i,
    input  logic [3:0]             sel_i,
    input  logic [31:0]            data_i,
    output logic [31:0]            data_o,
    output logic                   done_o,
    output logic                   stall_o,
    output logic [SRAM_ADDR_W-1:0] sram_addr_o,
    inout  wire  [31:0]            sram_data_io,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic [3:0]             sram_be_n
);
    logic [2:0]             r_state;
    logic [3:0]             r_cnt;
    logic                   r_we;
    logic [31:0]            r_wdata;
    logic                   r_drive;
    logic [SRAM_ADDR_W-1:0] r_addr;
    logic                   r_ce_n;
    logic                   r_oe_n;
    logic                   r_we_n;
    logic [3:0]             r_be_n;
    logic [31:0]            r_data_o;
    logic                   r_done;

    logic [SRAM_ADDR_W-1:0] w_addr;
    logic                   w_last;
    logic                   w_hit;
    logic [31:0]            w_buf_data;
    logic                   w_unused;

    assign w_addr   = addr_i[SRAM_ADDR_W+1:2];
    assign w_unused = ^{addr_i[31:SRAM_ADDR_W+2], addr_i[1:0]};
    assign w_last   = (r_cnt == 4'd0);

`ifdef SRAM_CTRL_RDBUF_EN
    logic w_fill;
    logic w_inv;

    assign w_fill = (r_state == S_ACCESS) && w_last && !r_we;
    assign w_inv  = (r_state == S_IDLE) && ce_i && we_i && (sel_i != 4'b0000);

    sram_ctrl_rdbuf #(.AW(SRAM_ADDR_W)) u_rdbuf (
        .clk           (clk),
        .rst           (rst),
        .i_lookup_addr (w_addr),
        .i_fill        (w_fill),
        .i_fill_addr   (r_addr),
        .i_fill_data   (sram_data_io),
        .i_inv         (w_inv),
        .i_inv_addr    (w_addr),
        .o_hit         (w_hit),
        .o_data        (w_buf_data)
    );
`else
    assign w_hit      = FALSE;
    assign w_buf_data = ZERO_WORD;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= FALSE;
            r_wdata  <= ZERO_WORD;
            r_drive  <= FALSE;
            r_addr   <= '0;
            r_ce_n   <= TRUE;
            r_oe_n   <= TRUE;
            r_we_n   <= TRUE;
            r_be_n   <= 4'hF;
            r_data_o <= ZERO_WORD;
            r_done   <= FALSE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ce_i) begin
                        r_we    <= we_i;
                        r_wdata <= data_i;
                        // Empty writes and buffer hits complete without touching the bus.
                        if (we_i && (sel_i == 4'b0000)) begin
                            r_state <= S_DONE;
                            r_done  <= TRUE;
                        end else if (!we_i && w_hit) begin
                            r_state  <= S_DONE;
                            r_done   <= TRUE;
                            r_data_o <= w_buf_data;
                        end else begin
                            r_state <= S_SETUP;
                            r_ce_n  <= FALSE;
                            r_addr  <= w_addr;
                            r_be_n  <= we_i ? ~sel_i : 4'b0000;
                        end
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                    r_cnt   <= 4'(WAIT_CYCLES - 1);
                    if (r_we) begin
                        r_we_n  <= FALSE;
                        r_drive <= TRUE;
                    end else begin
                        r_oe_n  <= FALSE;
                    end
                end
                S_ACCESS: begin
                    if (w_last) begin
                        if (r_we) begin
                            r_state <= S_HOLD;
                            r_we_n  <= TRUE;
                        end else begin
                            r_state  <= S_DONE;
                            r_oe_n   <= TRUE;
                            r_ce_n   <= TRUE;
                            r_be_n   <= 4'hF;
                            r_data_o <= sram_data_io;
                            r_done   <= TRUE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    r_state <= S_DONE;
                    r_drive <= FALSE;
                    r_ce_n  <= TRUE;
                    r_be_n  <= 4'hF;
                    r_done  <= TRUE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= FALSE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sram_data_io = r_drive ? r_wdata : 32'bz;
    assign sram_addr_o  = r_addr;
    assign sram_ce_n    = r_ce_n;
    assign sram_oe_n    = r_oe_n;
    assign sram_we_n    = r_we_n;
    assign sram_be_n    = r_be_n;
    assign data_o       = r_data_o;
    assign done_o       = r_done;
    assign stall_o      = ce_i & ~r_done;
endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural async SRAM; read-buffer expectations
// follow SRAM_CTRL_RDBUF_EN.
`timescale 1ns/1ps
module tb_sram_ctrl;
    localparam int AW = 20;
    localparam int WC = 2;
`ifdef SRAM_CTRL_RDBUF_EN
    localparam bit RDBUF = 1'b1;
`else
    localparam bit RDBUF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ce_i = 1'b0, we_i = 1'b0;
    logic [31:0]   addr_i = '0, data_i = '0;
    logic [3:0]    sel_i = '0;
    logic [31:0]   data_o;
    logic          done_o, stall_o;
    logic [AW-1:0] sram_addr_o;
    wire  [31:0]   sram_data_io;
    logic          sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]    sram_be_n;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          lat;
        int          acc;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0;
    int          oe_lo = 0, we_lo = 0, ce_lo = 0, ovl = 0;
    logic [3:0]  last_be = 4'h5;
    logic [31:0] mem [0:1023];

    sram_ctrl #(.SRAM_ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .sel_i        (sel_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .done_o       (done_o),
        .stall_o      (stall_o),
        .sram_addr_o  (sram_addr_o),
        .sram_data_io (sram_data_io),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_be_n    (sram_be_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Async SRAM: drives while selected with OE low, commits enabled bytes on the WE rising edge.
    assign sram_data_io = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr_o[9:0]] : 32'bz;
    always @(posedge sram_we_n) begin
        if (!rst && !sram_ce_n) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) mem[sram_addr_o[9:0]][8*b +: 8] = sram_data_io[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (!sram_oe_n) oe_lo++;
            if (!sram_we_n) we_lo++;
            if (!sram_ce_n) begin
                ce_lo++;
                last_be = sram_be_n;
            end
            if (!sram_oe_n && !sram_we_n) ovl++;
            if (done_o) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk({mon_e.tag, "_lat"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    if (mon_e.rd) chk({mon_e.tag, "_data"}, data_o, mon_e.data);
                end
            end
        end
    end

    // Called at a negedge. b2b: controller is in DONE now, so acceptance is two edges away.
    // keep: leave ce_i asserted on return (returns on the done_o cycle).
    task automatic req(input string tag, input logic we, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] rexp, input int lat,
                       input bit b2b, input bit keep, input bit early);
        exp_t e;
        int   n;
        ce_i = 1'b1; we_i = we; addr_i = a; sel_i = s; data_i = d;
        oe_lo = 0; we_lo = 0; ce_lo = 0; last_be = 4'h5;
        repeat (b2b ? 2 : 1) @(posedge clk);
        #1;
        e.rd = !we; e.data = rexp; e.lat = lat; e.acc = cyc; e.tag = tag;
        sbq.push_back(e);
        @(negedge clk);
        if (early) ce_i = 1'b0;
        n = 0;
        while (!done_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done_o) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            sbq.delete();
        end
        chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        if (!keep) begin
            ce_i = 1'b0; we_i = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[16] = 32'h1122_3344;
        rst = 1'b1;
        #1;
        chk("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_be_n", {28'd0, sram_be_n}, 32'hF);
        chk("rst_addr", {12'd0, sram_addr_o}, 32'd0);
        chk("rst_data_o", data_o, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic read and byte-lane write
        req("rd1", 1'b0, 32'h40, 4'hF, 32'h0, 32'h1122_3344, WC + 1, 0, 0, 0);
        chk("rd1_oe_cycles", 32'(oe_lo), 32'(WC));
        chk("rd1_ce_cycles", 32'(ce_lo), 32'(WC + 1));
        chk("rd1_be", {28'd0, last_be}, 32'h0);
        req("wr1", 1'b1, 32'h40, 4'b0010, 32'hAAAA_AAAA, 32'h0, WC + 2, 0, 0, 0);
        chk("wr1_we_cycles", 32'(we_lo), 32'(WC));
        chk("wr1_ce_cycles", 32'(ce_lo), 32'(WC + 2));
        chk("wr1_be", {28'd0, last_be}, 32'hD);
        chk("wr1_keeps_data_o", data_o, 32'h1122_3344);
        chk("wr1_mem", mem[16], 32'h1122_AA44);
        req("rd2", 1'b0, 32'h40, 4'h0, 32'h0, 32'h1122_AA44, WC + 1, 0, 0, 0);

        // Empty write: no bus activity, done right after the accept cycle
        req("wr0", 1'b1, 32'h40, 4'b0000, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0);
        chk("wr0_ce_cycles", 32'(ce_lo), 32'd0);
        chk("wr0_we_cycles", 32'(we_lo), 32'd0);
        chk("wr0_mem", mem[16], 32'h1122_AA44);

        // Repeat read: buffer hit when enabled, else a full bus cycle
        req("rd3", 1'b0, 32'h40, 4'h0, 32'h0, 32'h1122_AA44, RDBUF ? 0 : WC + 1, 0, 0, 0);
        chk("rd3_ce_cycles", 32'(ce_lo), RDBUF ? 32'd0 : 32'(WC + 1));
        req("wr2", 1'b1, 32'h40, 4'b1000, 32'h9999_9999, 32'h0, WC + 2, 0, 0, 0);
        req("rd4", 1'b0, 32'h40, 4'h0, 32'h0, 32'h9922_AA44, WC + 1, 0, 0, 0);
        chk("rd4_ce_cycles", 32'(ce_lo), 32'(WC + 1));

        // Reset in the middle of a write access
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h80; sel_i = 4'hF; data_i = 32'h5555_5555;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("abort_we_low", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("abort_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("abort_data_o", data_o, 32'd0);
        ce_i = 1'b0; we_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_done", {31'd0, done_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        req("wr3", 1'b1, 32'h80, 4'hF, 32'hCAFE_F00D, 32'h0, WC + 2, 0, 0, 0);
        req("rd5", 1'b0, 32'h80, 4'h0, 32'h0, 32'hCAFE_F00D, WC + 1, 0, 0, 0);
        // ce_i dropped after accept; reset also emptied the buffer
        req("rd6", 1'b0, 32'h40, 4'h0, 32'h0, 32'h9922_AA44, WC + 1, 0, 0, 1);

        // Back-to-back: ce_i held through done_o, next request accepted after DONE
        ovl = 0;
        req("wr4", 1'b1, 32'h100, 4'hF, 32'h1234_5678, 32'h0, WC + 2, 0, 1, 0);
        req("rd7", 1'b0, 32'h100, 4'h0, 32'h0, 32'h1234_5678, WC + 1, 1, 0, 0);
        chk("oe_we_overlap", 32'(ovl), 32'd0);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
